// File: rtl/temp_seq_ctrl.sv
// temp_seq_ctrl: measurement sequencer for a DS18B20-type sensor on a 1-wire bus.
// Each accepted start runs:
//   RESET, SKIP ROM, CONVERT T, conversion wait, RESET, SKIP ROM, READ SCRATCHPAD,
//   then NREAD byte reads.
// It drives a byte-level 1-wire engine through a request/done handshake.
// Optional feature macro: TEMP_SEQ_CRC_EN. When defined, the full 9-byte scratchpad
// is read and checked with a Dallas CRC-8 before out_temp is updated.
// Ports:
//   in_clk, in_rst (sync, active high), in_start
//   out_busy, out_temp[15:0], out_valid, out_err
//   1-wire engine side: out_bus_req, out_bus_cmd[1:0], out_bus_data[7:0],
//                       in_bus_ready, in_bus_done, in_bus_data[7:0], in_bus_presence
module temp_seq_ctrl #(
  parameter int unsigned MAIN_CLK     = 27_000_000,
  parameter int unsigned CONV_WAIT_US = 750_000,
  parameter logic [7:0]  CMD_SKIP_ROM = 8'hCC,
  parameter logic [7:0]  CMD_CONVERT  = 8'h44,
  parameter logic [7:0]  CMD_READ_SP  = 8'hBE
) (
  input  logic        in_clk,
  input  logic        in_rst,
  input  logic        in_start,
  output logic        out_busy,
  output logic [15:0] out_temp,
  output logic        out_valid,
  output logic        out_err,
  output logic        out_bus_req,
  output logic [1:0]  out_bus_cmd,
  output logic [7:0]  out_bus_data,
  input  logic        in_bus_ready,
  input  logic        in_bus_done,
  input  logic [7:0]  in_bus_data,
  input  logic        in_bus_presence
);

  localparam int unsigned WAIT_CYCLES = MAIN_CLK / 1_000_000 * CONV_WAIT_US;
  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
`ifdef TEMP_SEQ_CRC_EN
  localparam int unsigned NREAD = 9;
`else
  localparam int unsigned NREAD = 2;
`endif
  localparam int unsigned IDX_W = $clog2(NREAD);

  localparam logic [1:0] BUS_RESET = 2'd0;
  localparam logic [1:0] BUS_WRITE = 2'd1;
  localparam logic [1:0] BUS_READ  = 2'd2;

  typedef enum logic [4:0] {
    S_IDLE, S_RST1_I, S_RST1_W, S_SKIP1_I, S_SKIP1_W, S_CONV_I, S_CONV_W, S_WAIT,
    S_RST2_I, S_RST2_W, S_SKIP2_I, S_SKIP2_W, S_RDSP_I, S_RDSP_W, S_RD_I, S_RD_W,
`ifdef TEMP_SEQ_CRC_EN
    S_CRC, S_CRC_CHK,
`endif
    S_DONE
  } state_t;

  state_t           state, state_d;
  logic             req, req_d, busy, valid, valid_d, err, err_d;
  logic [1:0]       cmd, cmd_d;
  logic [7:0]       data, data_d;
  logic [15:0]      temp, temp_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [IDX_W-1:0] idx, idx_d;
  logic [7:0]       rx [NREAD];
  logic             rx_we;
  logic             got_done;

  // A done coinciding with our own request cycle cannot belong to it.
  assign got_done = in_bus_done && !req;

`ifdef TEMP_SEQ_CRC_EN
  logic [7:0] crc, crc_d, crc_byte;
  logic [5:0] bcnt, bcnt_d;
  logic       crc_fb;
  // Serial Dallas CRC-8, LSB first: bit bcnt[2:0] of byte bcnt[5:3].
  assign crc_byte = rx[4'(bcnt[5:3])];
  assign crc_fb   = crc[0] ^ crc_byte[bcnt[2:0]];
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d = state;
    req_d   = 1'b0;
    cmd_d   = cmd;
    data_d  = data;
    err_d   = err;
    temp_d  = temp;
    valid_d = 1'b0;
    cnt_d   = cnt;
    idx_d   = idx;
    rx_we   = 1'b0;
`ifdef TEMP_SEQ_CRC_EN
    crc_d   = crc;
    bcnt_d  = bcnt;
`endif
    case (state)
      S_IDLE: if (in_start) begin
        err_d   = 1'b0;
        state_d = S_RST1_I;
      end
      S_RST1_I, S_RST2_I: if (in_bus_ready) begin
        req_d   = 1'b1;
        cmd_d   = BUS_RESET;
        data_d  = 8'h00;
        state_d = (state == S_RST1_I) ? S_RST1_W : S_RST2_W;
      end
      S_RST1_W, S_RST2_W: if (got_done) begin
        if (!in_bus_presence) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = (state == S_RST1_W) ? S_SKIP1_I : S_SKIP2_I;
        end
      end
      S_SKIP1_I, S_SKIP2_I: if (in_bus_ready) begin
        req_d   = 1'b1;
        cmd_d   = BUS_WRITE;
        data_d  = CMD_SKIP_ROM;
        state_d = (state == S_SKIP1_I) ? S_SKIP1_W : S_SKIP2_W;
      end
      S_SKIP1_W: if (got_done) state_d = S_CONV_I;
      S_SKIP2_W: if (got_done) state_d = S_RDSP_I;
      S_CONV_I: if (in_bus_ready) begin
        req_d   = 1'b1;
        cmd_d   = BUS_WRITE;
        data_d  = CMD_CONVERT;
        state_d = S_CONV_W;
      end
      S_CONV_W: if (got_done) begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt == CNT_W'(WAIT_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_RST2_I;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      S_RDSP_I: if (in_bus_ready) begin
        req_d   = 1'b1;
        cmd_d   = BUS_WRITE;
        data_d  = CMD_READ_SP;
        state_d = S_RDSP_W;
      end
      S_RDSP_W: if (got_done) begin
        idx_d   = '0;
        state_d = S_RD_I;
      end
      S_RD_I: if (in_bus_ready) begin
        req_d   = 1'b1;
        cmd_d   = BUS_READ;
        data_d  = 8'h00;
        state_d = S_RD_W;
      end
      S_RD_W: if (got_done) begin
        rx_we = 1'b1;
        if (idx == IDX_W'(NREAD - 1)) begin
          idx_d = '0;
`ifdef TEMP_SEQ_CRC_EN
          crc_d   = 8'h00;
          bcnt_d  = 6'd0;
          state_d = S_CRC;
`else
          state_d = S_DONE;
`endif
        end else begin
          idx_d   = idx + IDX_W'(1);
          state_d = S_RD_I;
        end
      end
`ifdef TEMP_SEQ_CRC_EN
      S_CRC: begin
        crc_d  = {1'b0, crc[7:1]} ^ (crc_fb ? 8'h8C : 8'h00);
        bcnt_d = bcnt + 6'd1;
        if (bcnt == 6'd63) state_d = S_CRC_CHK;
      end
      S_CRC_CHK: begin
        if (crc == rx[8]) begin
          state_d = S_DONE;
        end else begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
`endif
      S_DONE: begin
        temp_d  = {rx[1], rx[0]};
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state <= S_IDLE;
      req   <= 1'b0;
      cmd   <= 2'd0;
      data  <= 8'h00;
      err   <= 1'b0;
      temp  <= 16'h0000;
      valid <= 1'b0;
      busy  <= 1'b0;
      cnt   <= '0;
      idx   <= '0;
      for (int i = 0; i < NREAD; i++) rx[i] <= 8'h00;
`ifdef TEMP_SEQ_CRC_EN
      crc   <= 8'h00;
      bcnt  <= 6'd0;
`endif
    end else begin
      state <= state_d;
      req   <= req_d;
      cmd   <= cmd_d;
      data  <= data_d;
      err   <= err_d;
      temp  <= temp_d;
      valid <= valid_d;
      busy  <= (state_d != S_IDLE);
      cnt   <= cnt_d;
      idx   <= idx_d;
      if (rx_we) rx[idx] <= in_bus_data;
`ifdef TEMP_SEQ_CRC_EN
      crc   <= crc_d;
      bcnt  <= bcnt_d;
`endif
    end
  end

  assign out_busy     = busy;
  assign out_temp     = temp;
  assign out_valid    = valid;
  assign out_err      = err;
  assign out_bus_req  = req;
  assign out_bus_cmd  = cmd;
  assign out_bus_data = data;

endmodule

// File: tb/tb_temp_seq_ctrl.sv
// tb_temp_seq_ctrl: directed bench for temp_seq_ctrl with a behavioural 1-wire engine.
// The engine answers each request three cycles later and logs every request.
module tb_temp_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, valid, err, bus_req;
  logic [15:0] temp;
  logic [1:0]  bus_cmd;
  logic [7:0]  bus_data;
  logic        bus_ready = 1'b1;
  logic        bus_done = 1'b0;
  logic [7:0]  bus_rdata = 8'h00;
  logic        bus_presence = 1'b0;

  int n_checks = 0;
  int n_pass = 0;

  logic [7:0] rd_bytes [9];
  int         rd_ptr = 0;
  bit         pres_cfg = 1'b1;
  logic [1:0] log_cmd [$];
  logic [7:0] log_data [$];
  int         log_cyc [$];
  int         cyc = 0;
  int         conv_done_cyc = 0;
  int         valid_cnt = 0;
  bit         eng_active = 1'b0;
  int         tmr = 0;
  logic [1:0] act_cmd = 2'd0;
  logic [7:0] act_data = 8'h00;

  temp_seq_ctrl #(.MAIN_CLK(27_000_000), .CONV_WAIT_US(1)) dut (
    .in_clk(clk), .in_rst(rst), .in_start(start),
    .out_busy(busy), .out_temp(temp), .out_valid(valid), .out_err(err),
    .out_bus_req(bus_req), .out_bus_cmd(bus_cmd), .out_bus_data(bus_data),
    .in_bus_ready(bus_ready), .in_bus_done(bus_done), .in_bus_data(bus_rdata),
    .in_bus_presence(bus_presence)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Behavioural 1-wire engine, driven on the falling edge.
  initial forever begin
    @(negedge clk);
    bus_done = 1'b0;
    if (eng_active) begin
      tmr--;
      if (tmr == 0) begin
        bus_done   = 1'b1;
        eng_active = 1'b0;
        bus_ready  = 1'b1;
        if (act_cmd == 2'd2 && rd_ptr < 9) begin
          bus_rdata = rd_bytes[rd_ptr];
          rd_ptr++;
        end
        if (act_cmd == 2'd0) bus_presence = pres_cfg;
        if (act_cmd == 2'd1 && act_data == 8'h44) conv_done_cyc = cyc;
      end
    end else if (bus_req) begin
      log_cmd.push_back(bus_cmd);
      log_data.push_back(bus_data);
      log_cyc.push_back(cyc);
      act_cmd    = bus_cmd;
      act_data   = bus_data;
      eng_active = 1'b1;
      tmr        = 3;
      bus_ready  = 1'b0;
    end
    if (valid) valid_cnt++;
  end

  task automatic start_meas();
    log_cmd.delete();
    log_data.delete();
    log_cyc.delete();
    rd_ptr    = 0;
    valid_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    bit done_ok = 1'b0;
    for (int i = 0; i < 3000 && !done_ok; i++) begin
      if (!busy) done_ok = 1'b1;
      else @(negedge clk);
    end
    n_checks++;
    if (!done_ok) $display("FAIL wait_idle: busy still %b after 3000 cycles, need 0", busy);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic check_log(input string name, input int exp_size, input logic [15:0] exp_seq,
                           input logic [31:0] exp_writes);
    logic [15:0] seq = 16'h0;
    logic [31:0] wr = 32'h0;
    for (int i = 0; i < log_cmd.size(); i++) begin
      seq = {seq[13:0], log_cmd[i]};
      if (log_cmd[i] == 2'd1) wr = {wr[23:0], log_data[i]};
    end
    n_checks++;
    if (log_cmd.size() !== exp_size)
      $display("FAIL %s_req_count: got %0d need %0d", name, log_cmd.size(), exp_size);
    else n_pass++;
    n_checks++;
    if (seq !== exp_seq) $display("FAIL %s_cmd_order: got %h need %h", name, seq, exp_seq);
    else n_pass++;
    n_checks++;
    if (wr !== exp_writes) $display("FAIL %s_writes: got %h need %h", name, wr, exp_writes);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if ({busy, valid, err, bus_req} !== 4'b0000)
      $display("FAIL reset_flags: got %b need 0000", {busy, valid, err, bus_req}); else n_pass++;
    n_checks++; if (temp !== 16'h0000)
      $display("FAIL reset_temp: got %h need 0000", temp); else n_pass++;
    n_checks++; if ({bus_cmd, bus_data} !== 10'h000)
      $display("FAIL reset_bus: got %h need 000", {bus_cmd, bus_data}); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Expected command order RESET,W,W,RESET,W,W,READ,READ = 00 01 01 00 01 01 10 10.
  task automatic test_normal_read();
    pres_cfg = 1'b1;
    rd_bytes[0] = 8'h91; rd_bytes[1] = 8'h01;
    start_meas();
    n_checks++; if (busy !== 1'b1)
      $display("FAIL normal_busy: got %b need 1", busy); else n_pass++;
    wait_idle();
    n_checks++; if (temp !== 16'h0191)
      $display("FAIL normal_temp: got %h need 0191", temp); else n_pass++;
    n_checks++; if (valid_cnt !== 1)
      $display("FAIL normal_valid_pulses: got %0d need 1", valid_cnt); else n_pass++;
    n_checks++; if (err !== 1'b0)
      $display("FAIL normal_err: got %b need 0", err); else n_pass++;
    check_log("normal", 8, 16'h145A, 32'hCC44CCBE);
    n_checks++;
    if (log_cyc.size() < 4 || (log_cyc[3] - conv_done_cyc) < 27)
      $display("FAIL wait_gap: got %0d need >=27",
               (log_cyc.size() < 4) ? -1 : log_cyc[3] - conv_done_cyc);
    else n_pass++;
  endtask

  task automatic test_no_presence();
    pres_cfg = 1'b0;
    start_meas();
    wait_idle();
    n_checks++; if (err !== 1'b1)
      $display("FAIL nopres_err: got %b need 1", err); else n_pass++;
    n_checks++; if (busy !== 1'b0)
      $display("FAIL nopres_busy: got %b need 0", busy); else n_pass++;
    n_checks++; if (temp !== 16'h0191)
      $display("FAIL nopres_temp_kept: got %h need 0191", temp); else n_pass++;
    n_checks++; if (valid_cnt !== 0)
      $display("FAIL nopres_valid: got %0d need 0", valid_cnt); else n_pass++;
    n_checks++; if (log_cmd.size() !== 1)
      $display("FAIL nopres_req_count: got %0d need 1", log_cmd.size()); else n_pass++;
  endtask

  task automatic test_negative();
    pres_cfg = 1'b1;
    rd_bytes[0] = 8'h5E; rd_bytes[1] = 8'hFF;
    start_meas();
    n_checks++; if (err !== 1'b0)
      $display("FAIL neg_err_cleared: got %b need 0", err); else n_pass++;
    wait_idle();
    n_checks++; if (temp !== 16'hFF5E)
      $display("FAIL neg_temp: got %h need FF5E", temp); else n_pass++;
    n_checks++; if (valid_cnt !== 1)
      $display("FAIL neg_valid: got %0d need 1", valid_cnt); else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit seen = 1'b0;
    rd_bytes[0] = 8'h91; rd_bytes[1] = 8'h01;
    log_cmd.delete(); log_data.delete(); log_cyc.delete();
    rd_ptr = 0; valid_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (valid) seen = 1'b1;
    end
    n_checks++; if (!seen || busy !== 1'b0)
      $display("FAIL b2b_first_done: seen %b busy %b need 1/0", seen, busy); else n_pass++;
    rd_ptr = 0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b1)
      $display("FAIL b2b_retrigger: got %b need 1", busy); else n_pass++;
    start = 1'b0;
    wait_idle();
    n_checks++; if (valid_cnt !== 2)
      $display("FAIL b2b_valid_pulses: got %0d need 2", valid_cnt); else n_pass++;
    n_checks++; if (temp !== 16'h0191)
      $display("FAIL b2b_temp: got %h need 0191", temp); else n_pass++;
  endtask

  task automatic test_reset_abort();
    bit ok = 1'b0;
    rd_bytes[0] = 8'h34; rd_bytes[1] = 8'h12;
    start_meas();
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (log_cmd.size() >= 7) ok = 1'b1;
    end
    n_checks++; if (!ok)
      $display("FAIL abort_reach_rdbyte: got %0d reqs need 7", log_cmd.size()); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if ({busy, valid, err, bus_req, bus_cmd, bus_data, temp} !== 30'h0)
      $display("FAIL abort_outputs: got %h need 0",
               {busy, valid, err, bus_req, bus_cmd, bus_data, temp}); else n_pass++;
    rst = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (bus_ready && !eng_active) ok = 1'b1;
    end
    rd_bytes[0] = 8'h91; rd_bytes[1] = 8'h01;
    start_meas();
    wait_idle();
    n_checks++; if (temp !== 16'h0191 || valid_cnt !== 1)
      $display("FAIL abort_rerun: temp %h valid %0d need 0191/1", temp, valid_cnt); else n_pass++;
    check_log("rerun", 8, 16'h145A, 32'hCC44CCBE);
  endtask

`ifdef TEMP_SEQ_CRC_EN
  task automatic test_crc();
    rd_bytes = '{8'h50, 8'h05, 8'h4B, 8'h46, 8'h7F, 8'hFF, 8'h0C, 8'h10, 8'h1C};
    start_meas();
    wait_idle();
    n_checks++; if (temp !== 16'h0550 || valid_cnt !== 1 || err !== 1'b0)
      $display("FAIL crc_good: temp %h valid %0d err %b need 0550/1/0", temp, valid_cnt, err);
    else n_pass++;
    rd_bytes[8] = 8'h1D;
    start_meas();
    wait_idle();
    n_checks++; if (temp !== 16'h0550 || valid_cnt !== 0 || err !== 1'b1)
      $display("FAIL crc_bad: temp %h valid %0d err %b need 0550/0/1", temp, valid_cnt, err);
    else n_pass++;
  endtask
`endif

  initial begin
    for (int i = 0; i < 9; i++) rd_bytes[i] = 8'h00;
    test_reset();
    test_normal_read();
    test_no_presence();
    test_negative();
    test_back_to_back();
    test_reset_abort();
`ifdef TEMP_SEQ_CRC_EN
    test_crc();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
